stop_wait_arbiter: RTL

STOP_WAIT_ARBITER -- requirements
Module: stop_wait_arbiter

---
 rtl/stop_wait_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/stop_wait_arbiter.sv
// Round-robin arbiter granting one requester at a time to a stop-and-wait resource.
// Optional WAIT-state abort is built when STOP_WAIT_ARB_TIMEOUT_EN is defined.
module stop_wait_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       start,
  input  logic                       done,
  output logic                       busy,
  output logic                       timeout
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] GRANT_ONE = NUM_REQ'(1);
  localparam logic [ID_W-1:0]    LAST_IDX  = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t          state;
  logic [ID_W-1:0] last_id;
  logic [ID_W-1:0] pick_id;
  logic            pick_found;
  logic            wait_expired;

  // Rotating priority search: first set req bit after last_id, wrapping to 0.
  always_comb begin
    int unsigned idx;
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(last_id) + i) % NUM_REQ;
      if (!pick_found && req[idx]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      start    <= 1'b0;
      busy     <= 1'b0;
      last_id  <= LAST_IDX;
    end else begin
      start <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            state    <= ISSUE;
            grant    <= GRANT_ONE << pick_id;
            grant_id <= pick_id;
            start    <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          // done and an expiring counter both release the grant; done has priority for timeout
          if (done || wait_expired) begin
            state   <= IDLE;
            grant   <= '0;
            busy    <= 1'b0;
            last_id <= grant_id;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef STOP_WAIT_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;

  // Counts WAIT cycles; expires at the end of the TIMEOUT_CYCLES-th one.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= (state == WAIT) && !done && wait_expired;
      if (state == ISSUE) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

  assign wait_expired = (wait_cnt == CNT_LAST);
`else
  assign wait_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  // Structural invariants of the grant outputs.
  a_param_range: assert property (@(posedge clk)
    (NUM_REQ >= 2) && (NUM_REQ <= 16) && (TIMEOUT_CYCLES >= 1) && (TIMEOUT_CYCLES <= 65535));
  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_busy_grant:   assert property (@(posedge clk) disable iff (rst) busy == (grant != '0));
  a_start_busy:   assert property (@(posedge clk) disable iff (rst) start |-> busy);

endmodule
